// File: rtl/riscv_boot_ctrl_pkg.sv
// riscv_boot_pkg: shared types and constants for the riscv_boot_ctrl slice.
//   boot_state_e       - sequencer state encoding
//   REG_ID_WIDTH       - width of the core debug register index
//   DEFAULT_ADDR_WIDTH - default instruction-memory word-address width
//   DEFAULT_CYC_WIDTH  - default run-cycle counter width
package riscv_boot_pkg;

  localparam int REG_ID_WIDTH       = 5;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_CYC_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RST,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } boot_state_e;

endpackage

// File: rtl/riscv_boot_ctrl_if.sv
// riscv_boot_ctrl_if: program-image stream (valid/ready) feeding the boot
// sequencer.
//   in_valid - stream word valid (source -> sequencer)
//   in_data  - stream word       (source -> sequencer)
//   in_ready - word accepted     (sequencer -> source)
// Modports: master = stream source, slave = boot sequencer.
interface riscv_boot_ctrl_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/riscv_boot_ctrl_reg_dump_seq.sv
// reg_dump_seq: walks the core debug port through register ids
// 0..NUM_REGS-1 and captures each sample one cycle later.
//   clock, reset     - clock and synchronous active-high reset
//   clr              - clears the id counter (session abort)
//   en               - advance one id this cycle and capture its value
//   last             - the id issued this cycle is the final one
//   reg_out_id       - id presented to the core debug port
//   reg_out_data     - value returned by the core for reg_out_id
//   dump_valid/id/data - registered dump word
module reg_dump_seq
  import riscv_boot_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  output logic                    last,
  output logic [REG_ID_WIDTH-1:0] reg_out_id,
  input  logic [DATA_WIDTH-1:0]   reg_out_data,
  output logic                    dump_valid,
  output logic [REG_ID_WIDTH-1:0] dump_id,
  output logic [DATA_WIDTH-1:0]   dump_data
);

  localparam logic [REG_ID_WIDTH-1:0] LAST_ID = REG_ID_WIDTH'(NUM_REGS - 1);

  logic [REG_ID_WIDTH-1:0] id_cnt_reg;
  logic                    dump_valid_reg;
  logic [REG_ID_WIDTH-1:0] dump_id_reg;
  logic [DATA_WIDTH-1:0]   dump_data_reg;

  // The counter wraps back to 0 after the final id, so it already sits at 0
  // for the next session and the debug port idles on register 0.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      id_cnt_reg <= '0;
    end else if (en) begin
      id_cnt_reg <= last ? '0 : id_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dump_valid_reg <= 1'b0;
      dump_id_reg    <= '0;
      dump_data_reg  <= '0;
    end else begin
      dump_valid_reg <= en;
      if (en) begin
        dump_id_reg   <= id_cnt_reg;
        dump_data_reg <= reg_out_data;
      end
    end
  end

  assign last       = (id_cnt_reg == LAST_ID);
  assign reg_out_id = id_cnt_reg;
  assign dump_valid = dump_valid_reg;
  assign dump_id    = dump_id_reg;
  assign dump_data  = dump_data_reg;

endmodule

// File: rtl/riscv_boot_ctrl.sv
// riscv_boot_ctrl: program-load and run sequencer for the Riscv core.
// Streams load_len words into instruction memory with the core held in
// reset, pulses core reset, runs the core for run_cycles cycles, then freezes
// it and dumps NUM_REGS registers through the core debug port.
//   clock, reset        - clock and synchronous active-high reset
//   start, abort        - session control (abort wins over everything)
//   load_len, run_cycles- session parameters, latched on start
//   stream              - program-image stream (slave side)
//   fetch_ram_load, imem_we/addr/wdata - instruction-memory load port
//   core_reset_n, core_clk_en          - core control
//   reg_out_id, reg_out_data           - core debug port
//   dump_valid/id/data                 - register dump output
//   busy, done                         - session status
module riscv_boot_ctrl
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CYC_WIDTH  = DEFAULT_CYC_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   load_len,
  input  logic [CYC_WIDTH-1:0]    run_cycles,
  riscv_boot_ctrl_if.slave        stream,
  output logic                    fetch_ram_load,
  output logic                    imem_we,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [DATA_WIDTH-1:0]   imem_wdata,
  output logic                    core_reset_n,
  output logic                    core_clk_en,
  output logic [REG_ID_WIDTH-1:0] reg_out_id,
  input  logic [DATA_WIDTH-1:0]   reg_out_data,
  output logic                    dump_valid,
  output logic [REG_ID_WIDTH-1:0] dump_id,
  output logic [DATA_WIDTH-1:0]   dump_data,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);
  localparam logic [CYC_WIDTH-1:0]  ONE_CYC  = CYC_WIDTH'(1);

  boot_state_e state_reg, state_next;

  logic [ADDR_WIDTH-1:0] load_len_reg;
  logic [ADDR_WIDTH-1:0] load_cnt_reg;
  logic [CYC_WIDTH-1:0]  run_len_reg;
  logic [CYC_WIDTH-1:0]  run_cnt_reg;

  logic handshake;
  logic dump_en;
  logic dump_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    stream.in_ready = 1'b0;
    fetch_ram_load  = 1'b0;
    core_reset_n    = 1'b0;
    core_clk_en     = 1'b0;
    dump_en         = 1'b0;
    done            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (load_len != '0) ? ST_LOAD : ST_RST;
        end
      end
      ST_LOAD: begin
        fetch_ram_load = 1'b1;
        // An aborted cycle must not accept a word it will never write.
        stream.in_ready = !abort;
        if (stream.in_valid && load_cnt_reg == load_len_reg - ONE_ADDR) begin
          state_next = ST_RST;
        end
      end
      ST_RST: begin
        state_next = (run_len_reg != '0) ? ST_RUN : ST_DUMP;
      end
      ST_RUN: begin
        core_reset_n = 1'b1;
        core_clk_en  = 1'b1;
        if (run_cnt_reg == run_len_reg - ONE_CYC) begin
          state_next = ST_DUMP;
        end
      end
      ST_DUMP: begin
        core_reset_n = 1'b1;
        dump_en      = !abort;
        if (dump_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        core_reset_n = 1'b1;
        done         = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
    end
  end

  assign handshake  = stream.in_valid && stream.in_ready;
  assign imem_we    = handshake;
  assign imem_addr  = (state_reg == ST_LOAD) ? load_cnt_reg : '0;
  assign imem_wdata = handshake ? stream.in_data : '0;
  assign busy       = (state_reg != ST_IDLE);

  // Counters restart from zero whenever the sequencer is idle or aborted, so
  // every session begins loading at address 0 and running from cycle 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      load_len_reg <= '0;
      run_len_reg  <= '0;
      load_cnt_reg <= '0;
      run_cnt_reg  <= '0;
    end else if (abort || state_reg == ST_IDLE) begin
      load_cnt_reg <= '0;
      run_cnt_reg  <= '0;
      if (!abort && start) begin
        load_len_reg <= load_len;
        run_len_reg  <= run_cycles;
      end
    end else begin
      if (handshake) begin
        load_cnt_reg <= load_cnt_reg + ONE_ADDR;
      end
      if (state_reg == ST_RUN) begin
        run_cnt_reg <= run_cnt_reg + ONE_CYC;
      end
    end
  end

  reg_dump_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_dump (
    .clock        (clock),
    .reset        (reset),
    .clr          (abort),
    .en           (dump_en),
    .last         (dump_last),
    .reg_out_id   (reg_out_id),
    .reg_out_data (reg_out_data),
    .dump_valid   (dump_valid),
    .dump_id      (dump_id),
    .dump_data    (dump_data)
  );

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Directed bench for riscv_boot_ctrl. A tiny behavioural core (ADDI-only,
// x0 hard-wired to 0) executes the loaded image so dumped register values
// come from real instruction execution.
module tb_riscv_boot_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [9:0]  load_len;
  logic [15:0] run_cycles;
  logic        fetch_ram_load;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset_n;
  logic        core_clk_en;
  logic [4:0]  reg_out_id;
  logic [31:0] reg_out_data;
  logic        dump_valid;
  logic [4:0]  dump_id;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;

  riscv_boot_ctrl_if #(.DATA_WIDTH(32)) stream ();

  riscv_boot_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .load_len       (load_len),
    .run_cycles     (run_cycles),
    .stream         (stream.slave),
    .fetch_ram_load (fetch_ram_load),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .core_reset_n   (core_reset_n),
    .core_clk_en    (core_clk_en),
    .reg_out_id     (reg_out_id),
    .reg_out_data   (reg_out_data),
    .dump_valid     (dump_valid),
    .dump_id        (dump_id),
    .dump_data      (dump_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural core ----------------
  logic [31:0] tb_imem [1024];
  logic [31:0] tb_regs [32];
  logic [9:0]  tb_pc;

  always @(posedge clock) begin
    if (imem_we) tb_imem[imem_addr] <= imem_wdata;
  end

  always @(posedge clock) begin
    logic [31:0] ins;
    ins = tb_imem[tb_pc];
    if (!core_reset_n) begin
      for (int i = 0; i < 32; i++) tb_regs[i] <= 32'h0;
      tb_pc <= 10'd0;
    end else if (core_clk_en) begin
      if (ins[6:0] == 7'h13 && ins[14:12] == 3'b000 && ins[11:7] != 5'd0)
        tb_regs[ins[11:7]] <= tb_regs[ins[19:15]] + {{20{ins[31]}}, ins[31:20]};
      tb_pc <= tb_pc + 10'd1;
    end
  end

  assign reg_out_data = tb_regs[reg_out_id];

  // ---------------- checking ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] words [4];
  int we_cnt, en_cnt, dv_cnt, dv_first, done_cnt, done_idx, rst_idx, idle_idx;
  logic idle_clk_en, idle_rst_n;
  logic [31:0] dump_regs [32];

  task automatic start_session(input logic [9:0] len, input logic [15:0] cyc);
    load_len   = len;
    run_cycles = cyc;
    start      = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
  endtask

  // Cycle index 0 is the first cycle after the start edge.
  task automatic observe(input int max_cyc, input int valid_mode,
                         input int abort_at, input int start_at);
    int wi;
    wi = 0;
    we_cnt = 0; en_cnt = 0; dv_cnt = 0; dv_first = -1;
    done_cnt = 0; done_idx = -1; rst_idx = -1; idle_idx = -1;
    idle_clk_en = 1'bx; idle_rst_n = 1'bx;
    for (int i = 0; i < 32; i++) dump_regs[i] = 32'hBAD0BAD0;
    for (int idx = 0; idx < max_cyc; idx++) begin
      stream.in_valid = (valid_mode == 0) ? 1'b1 : ((idx % 2) == 1);
      stream.in_data  = (wi < 4) ? words[wi] : 32'h0;
      abort = (idx == abort_at);
      start = (idx == start_at);
      #1;
      if (imem_we) begin
        we_cnt++;
        chk("imem_addr", {22'h0, imem_addr}, wi);
        chk("imem_wdata", imem_wdata, (wi < 4) ? words[wi] : 32'h0);
      end
      if (stream.in_valid && stream.in_ready) wi++;
      if (core_clk_en) en_cnt++;
      if (rst_idx < 0 && busy && !fetch_ram_load && !core_reset_n) rst_idx = idx;
      if (dump_valid) begin
        if (dv_first < 0) dv_first = idx;
        dv_cnt++;
        dump_regs[dump_id] = dump_data;
      end
      if (done) begin
        done_cnt++;
        done_idx = idx;
      end
      if (!busy) begin
        idle_idx    = idx;
        idle_clk_en = core_clk_en;
        idle_rst_n  = core_reset_n;
        break;
      end
      @(posedge clock); #1;
    end
    stream.in_valid = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    chk("session_reached_idle", (idle_idx >= 0), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, stream.in_ready, 0);
    chk({tag, "_fetch_ram_load"}, fetch_ram_load, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_core_reset_n"}, core_reset_n, 0);
    chk({tag, "_core_clk_en"}, core_clk_en, 0);
    chk({tag, "_reg_out_id"}, reg_out_id, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_dump_id"}, dump_id, 0);
    chk({tag, "_dump_data"}, dump_data, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; abort = 1'b0;
    load_len = 10'd5; run_cycles = 16'd3;
    stream.in_valid = 1'b1; stream.in_data = 32'hDEADBEEF;
    for (int i = 0; i < 1024; i++) tb_imem[i] = 32'h0;
    for (int i = 0; i < 32; i++) tb_regs[i] = 32'h0;
    tb_pc = 10'd0;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0; start = 1'b0; stream.in_valid = 1'b0; stream.in_data = 32'h0;
    @(posedge clock); #1;

    // 1: single ADDI x10,x0,3 then 20 run cycles
    words[0] = 32'h00300513; words[1] = 32'h0; words[2] = 32'h0; words[3] = 32'h0;
    start_session(10'd1, 16'd20);
    observe(200, 0, -1, -1);
    $display("session 1: we=%0d clk_en=%0d dump=%0d done_at=%0d", we_cnt, en_cnt, dv_cnt, done_idx);
    chk("s1_we_cnt", we_cnt, 1);
    chk("s1_rst_idx", rst_idx, 1);
    chk("s1_clk_en_cnt", en_cnt, 20);
    chk("s1_dump_first", dv_first, 23);
    chk("s1_dump_cnt", dv_cnt, 32);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_done_idx", done_idx, 54);
    chk("s1_idle_idx", idle_idx, 55);
    for (int i = 0; i < 32; i++) chk($sformatf("s1_x%0d", i), dump_regs[i], (i == 10) ? 32'd3 : 32'd0);

    // 2: four words with valid on odd cycles only, 2 run cycles
    words[0] = 32'h00500093;  // addi x1,x0,5
    words[1] = 32'h00708113;  // addi x2,x1,7
    words[2] = 32'hFFF00193;  // addi x3,x0,-1
    words[3] = 32'h00110213;  // addi x4,x2,1
    start_session(10'd4, 16'd2);
    observe(200, 1, -1, -1);
    $display("session 2: we=%0d rst_at=%0d clk_en=%0d done_at=%0d", we_cnt, rst_idx, en_cnt, done_idx);
    chk("s2_we_cnt", we_cnt, 4);
    chk("s2_rst_idx", rst_idx, 8);
    chk("s2_clk_en_cnt", en_cnt, 2);
    chk("s2_done_idx", done_idx, 43);
    chk("s2_x1", dump_regs[1], 32'd5);
    chk("s2_x2", dump_regs[2], 32'd12);
    chk("s2_x3", dump_regs[3], 32'd0);
    chk("s2_x10", dump_regs[10], 32'd0);

    // 3: empty load, zero run cycles
    start_session(10'd0, 16'd0);
    observe(200, 0, -1, -1);
    $display("session 3: we=%0d clk_en=%0d dump=%0d done_at=%0d", we_cnt, en_cnt, dv_cnt, done_idx);
    chk("s3_we_cnt", we_cnt, 0);
    chk("s3_rst_idx", rst_idx, 0);
    chk("s3_clk_en_cnt", en_cnt, 0);
    chk("s3_dump_first", dv_first, 2);
    chk("s3_dump_cnt", dv_cnt, 32);
    chk("s3_done_idx", done_idx, 33);
    chk("s3_x1", dump_regs[1], 32'd0);

    // 4: abort in the fifth RUN cycle
    words[0] = 32'h00300513; words[1] = 32'h0; words[2] = 32'h0; words[3] = 32'h0;
    start_session(10'd1, 16'd20);
    observe(200, 0, 6, -1);
    $display("session 4: clk_en=%0d idle_at=%0d done=%0d", en_cnt, idle_idx, done_cnt);
    chk("s4_idle_idx", idle_idx, 7);
    chk("s4_clk_en_cnt", en_cnt, 5);
    chk("s4_idle_clk_en", idle_clk_en, 0);
    chk("s4_idle_rst_n", idle_rst_n, 0);
    chk("s4_done_cnt", done_cnt, 0);
    chk("s4_dump_cnt", dv_cnt, 0);

    // 5: start pulsed during DUMP is ignored
    start_session(10'd0, 16'd0);
    load_len = 10'd3;
    observe(200, 0, -1, 10);
    $display("session 5: dump=%0d done_at=%0d", dv_cnt, done_idx);
    chk("s5_dump_cnt", dv_cnt, 32);
    chk("s5_done_idx", done_idx, 33);
    chk("s5_done_cnt", done_cnt, 1);
    chk("s5_we_cnt", we_cnt, 0);
    @(posedge clock); #1;
    chk("s5_stays_idle", busy, 0);

    // 6: reset in the middle of LOAD, then a fresh session
    words[0] = 32'h00500093; words[1] = 32'h00708113;
    words[2] = 32'hFFF00193; words[3] = 32'h00110213;
    start_session(10'd4, 16'd3);
    stream.in_valid = 1'b1; stream.in_data = words[0];
    @(posedge clock); #1;
    stream.in_data = words[1];
    @(posedge clock); #1;
    stream.in_data = words[2];
    reset = 1'b1;
    @(posedge clock); #1;
    chk_all_zero("midload_reset");
    reset = 1'b0; stream.in_valid = 1'b0;
    @(posedge clock); #1;
    start_session(10'd4, 16'd3);
    observe(200, 0, -1, -1);
    $display("session 6: we=%0d clk_en=%0d done_at=%0d", we_cnt, en_cnt, done_idx);
    chk("s6_we_cnt", we_cnt, 4);
    chk("s6_rst_idx", rst_idx, 4);
    chk("s6_done_idx", done_idx, 40);
    chk("s6_x1", dump_regs[1], 32'd5);
    chk("s6_x2", dump_regs[2], 32'd12);
    chk("s6_x3", dump_regs[3], 32'hFFFFFFFF);
    chk("s6_x4", dump_regs[4], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
